// File: rtl/cq_last_deq_vt_cache_pkg.sv
// cq_last_deq_vt_cache_pkg: shared sizing, FSM states and entry layout for the last-dequeued-timestamp cache
package cq_last_deq_vt_cache_pkg;
  localparam int LOG_LAST_DEQ_VT_CACHE = 9;
  localparam int LVT_OBJECT_WIDTH = 32;
  localparam int LVT_TS_WIDTH = 32;
  typedef enum logic {INIT, READY} lvt_state_t;
  typedef struct packed {
    logic valid;
    logic [LVT_OBJECT_WIDTH-LOG_LAST_DEQ_VT_CACHE-1:0] tag;
    logic [LVT_TS_WIDTH-1:0] ts;
  } last_deq_vt_entry_t;
endpackage

// File: rtl/cq_last_deq_vt_cache_if.sv
// cq_last_deq_vt_cache_if: lookup, result and update channels between the commit queue and the cache
interface cq_last_deq_vt_cache_if #(
  parameter int OBJECT_WIDTH = 32,
  parameter int TS_WIDTH = 32
);
  logic lookup_valid;
  logic lookup_ready;
  logic [OBJECT_WIDTH-1:0] lookup_object;
  logic [TS_WIDTH-1:0] lookup_ts;
  logic result_valid;
  logic result_bypass;
  logic update_valid;
  logic update_ready;
  logic [OBJECT_WIDTH-1:0] update_object;
  logic [TS_WIDTH-1:0] update_ts;
  modport master (
    output lookup_valid, lookup_object, lookup_ts, update_valid, update_object, update_ts,
    input lookup_ready, result_valid, result_bypass, update_ready
  );
  modport slave (
    input lookup_valid, lookup_object, lookup_ts, update_valid, update_object, update_ts,
    output lookup_ready, result_valid, result_bypass, update_ready
  );
endinterface

// File: rtl/lvt_ram.sv
// lvt_ram: one write port, two registered read ports; reads return the pre-write contents
module lvt_ram
  import cq_last_deq_vt_cache_pkg::*;
#(
  parameter int AW = LOG_LAST_DEQ_VT_CACHE,
  parameter type entry_t = last_deq_vt_entry_t
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  entry_t wdata,
  input  logic [AW-1:0] a_addr,
  output entry_t a_data,
  input  logic [AW-1:0] b_addr,
  output entry_t b_data
);
  entry_t mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    a_data <= mem[a_addr];
    b_data <= mem[b_addr];
  end
endmodule

// File: rtl/cq_last_deq_vt_cache.sv
// cq_last_deq_vt_cache: per-object cache of the largest dequeued timestamp, lets lookups skip conflict checks
// Build option: LAST_DEQ_VT_STATS_EN adds saturating stat_lookups / stat_bypass counters.
module cq_last_deq_vt_cache
  import cq_last_deq_vt_cache_pkg::*;
#(
  parameter int LOG_ENTRIES = LOG_LAST_DEQ_VT_CACHE,
  parameter int OBJECT_WIDTH = 32,
  parameter int TS_WIDTH = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  output logic busy,
`ifdef LAST_DEQ_VT_STATS_EN
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_bypass,
`endif
  cq_last_deq_vt_cache_if.slave bus
);
  localparam int TAG_W = OBJECT_WIDTH - LOG_ENTRIES;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;
  lvt_state_t state;
  logic [LOG_ENTRIES-1:0] cnt, lk_idx, up_idx, u2_idx, waddr;
  logic rdy, lk_fire, up_fire, u2_we, u2_hit, we;
  logic res_valid, res_hz, u2_valid, u2_fwd;
  logic [TAG_W-1:0] res_tag;
  logic [TS_WIDTH-1:0] res_ts, u2_ts;
  logic [OBJECT_WIDTH-1:0] u2_obj;
  entry_t lk_rd, up_rd, u2_old, u2_new, u2_fwd_data, wdata;
  assign rdy = state == READY && !flush;
  assign bus.lookup_ready = rdy;
  assign bus.update_ready = rdy;
  assign busy = state == INIT;
  assign lk_fire = bus.lookup_valid && rdy;
  assign up_fire = bus.update_valid && rdy;
  assign lk_idx = bus.lookup_object[LOG_ENTRIES-1:0];
  assign up_idx = bus.update_object[LOG_ENTRIES-1:0];
  assign u2_idx = u2_obj[LOG_ENTRIES-1:0];
  // U2 merges against the previous U2 write when it hit the same index (RAM read was stale)
  assign u2_old = u2_fwd ? u2_fwd_data : up_rd;
  assign u2_hit = u2_old.valid && u2_old.tag == u2_obj[OBJECT_WIDTH-1:LOG_ENTRIES];
  assign u2_new = '{valid: 1'b1, tag: u2_obj[OBJECT_WIDTH-1:LOG_ENTRIES],
                    ts: (u2_hit && u2_old.ts > u2_ts) ? u2_old.ts : u2_ts};
  assign u2_we = u2_valid && !flush;
  assign we = busy || u2_we;
  assign waddr = busy ? cnt : u2_idx;
  assign wdata = busy ? '0 : u2_new;
  assign bus.result_valid = res_valid;
  assign bus.result_bypass = res_valid && !res_hz && !flush && lk_rd.valid &&
                             lk_rd.tag == res_tag && res_ts > lk_rd.ts;
  lvt_ram #(.AW(LOG_ENTRIES), .entry_t(entry_t)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .a_addr(lk_idx), .a_data(lk_rd), .b_addr(up_idx), .b_data(up_rd)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= INIT;
      cnt <= '0;
      res_valid <= 1'b0;
      res_hz <= 1'b0;
      u2_valid <= 1'b0;
      u2_fwd <= 1'b0;
    end else begin
      state <= state == INIT ? (&cnt ? READY : INIT) : (flush ? INIT : READY);
      cnt <= state == INIT ? cnt + 1'b1 : '0;
      res_valid <= lk_fire;
      res_hz <= (up_fire && up_idx == lk_idx) || (u2_valid && u2_idx == lk_idx);
      u2_valid <= up_fire;
      u2_fwd <= up_fire && u2_we && up_idx == u2_idx;
    end
  always_ff @(posedge clk) begin
    res_tag <= bus.lookup_object[OBJECT_WIDTH-1:LOG_ENTRIES];
    res_ts <= bus.lookup_ts;
    u2_obj <= bus.update_object;
    u2_ts <= bus.update_ts;
    u2_fwd_data <= u2_new;
  end
`ifdef LAST_DEQ_VT_STATS_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      stat_lookups <= '0;
      stat_bypass <= '0;
    end else begin
      if (bus.result_valid && !(&stat_lookups)) stat_lookups <= stat_lookups + 32'd1;
      if (bus.result_bypass && !(&stat_bypass)) stat_bypass <= stat_bypass + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cq_last_deq_vt_cache.sv
// tb_cq_last_deq_vt_cache: directed checks of init, hit/miss, monotonic merge, tag replace, hazards and flush
module tb_cq_last_deq_vt_cache;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int checks = 0;
  int failures = 0;
  int exp_lk = 0;
  int exp_bp = 0;
`ifdef LAST_DEQ_VT_STATS_EN
  logic [31:0] stat_lookups, stat_bypass;
`endif
  cq_last_deq_vt_cache_if bus();
  cq_last_deq_vt_cache dut (
    .clk(clk), .rstn(rstn), .flush(flush), .busy(busy),
`ifdef LAST_DEQ_VT_STATS_EN
    .stat_lookups(stat_lookups), .stat_bypass(stat_bypass),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_update(input logic [31:0] obj, input logic [31:0] ts);
    bus.update_valid = 1'b1;
    bus.update_object = obj;
    bus.update_ts = ts;
    @(negedge clk);
    bus.update_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] obj, input logic [31:0] ts, output logic rv, output logic bp);
    bus.lookup_valid = 1'b1;
    bus.lookup_object = obj;
    bus.lookup_ts = ts;
    @(negedge clk);
    rv = bus.result_valid;
    bp = bus.result_bypass;
    bus.lookup_valid = 1'b0;
    exp_lk++;
  endtask

  task automatic test_reset;
    int n = 0;
    bus.lookup_valid = 1'b0;
    bus.update_valid = 1'b0;
    bus.lookup_object = '0;
    bus.lookup_ts = '0;
    bus.update_object = '0;
    bus.update_ts = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.lookup_ready, bus.update_ready, bus.result_valid, bus.result_bypass, busy} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00001",
               {bus.lookup_ready, bus.update_ready, bus.result_valid, bus.result_bypass, busy});
    end
    rstn = 1'b1;
    bus.lookup_valid = 1'b1;
    bus.lookup_object = 32'd5;
    bus.lookup_ts = 32'd100;
    while (bus.lookup_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 512) begin
      failures++;
      $display("FAIL init_cycles got=%0d want=512", n);
    end
    checks++;
    if (busy !== 1'b0 || bus.update_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_init got busy=%b update_ready=%b want busy=0 update_ready=1", busy, bus.update_ready);
    end
    @(negedge clk);
    exp_lk++;
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_bypass !== 1'b0) begin
      failures++;
      $display("FAIL first_lookup got valid=%b bypass=%b want valid=1 bypass=0", bus.result_valid, bus.result_bypass);
    end
    bus.lookup_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0) begin
      failures++;
      $display("FAIL result_pulse got valid=%b want 0", bus.result_valid);
    end
  endtask

  task automatic test_update_hit;
    logic [31:0] objs [4];
    logic [31:0] tss [4];
    logic exs [4];
    logic rv, bp;
    objs = '{32'h205, 32'h205, 32'h205, 32'h005};
    tss = '{32'd51, 32'd50, 32'd49, 32'd51};
    exs = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_update(32'h205, 32'd50);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      do_lookup(objs[i], tss[i], rv, bp);
      exp_bp += int'(exs[i]);
      checks++;
      if (rv !== 1'b1 || bp !== exs[i]) begin
        failures++;
        $display("FAIL hit_%0d obj=%h ts=%0d got valid=%b bypass=%b want valid=1 bypass=%b", i, objs[i], tss[i], rv, bp, exs[i]);
      end
    end
  endtask

  task automatic test_monotonic;
    logic [31:0] objs [5];
    logic [31:0] tss [5];
    logic exs [5];
    logic rv, bp;
    objs = '{32'd7, 32'd7, 32'd7, 32'd8, 32'd8};
    tss = '{32'd70, 32'd80, 32'd81, 32'd70, 32'd81};
    exs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_update(32'd7, 32'd80);
    do_update(32'd7, 32'd60);
    do_update(32'd8, 32'd60);
    do_update(32'd8, 32'd80);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      do_lookup(objs[i], tss[i], rv, bp);
      exp_bp += int'(exs[i]);
      checks++;
      if (rv !== 1'b1 || bp !== exs[i]) begin
        failures++;
        $display("FAIL mono_%0d obj=%h ts=%0d got valid=%b bypass=%b want valid=1 bypass=%b", i, objs[i], tss[i], rv, bp, exs[i]);
      end
    end
  endtask

  task automatic test_tag_replace;
    logic [31:0] objs [5];
    logic [31:0] tss [5];
    logic exs [5];
    logic rv, bp;
    objs = '{32'h203, 32'h003, 32'h003, 32'h203, 32'h203};
    tss = '{32'd99, 32'd11, 32'd99, 32'd21, 32'd20};
    exs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_update(32'h003, 32'd10);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        do_update(32'h203, 32'd20);
        idle(2);
      end
      do_lookup(objs[i], tss[i], rv, bp);
      exp_bp += int'(exs[i]);
      checks++;
      if (rv !== 1'b1 || bp !== exs[i]) begin
        failures++;
        $display("FAIL tag_%0d obj=%h ts=%0d got valid=%b bypass=%b want valid=1 bypass=%b", i, objs[i], tss[i], rv, bp, exs[i]);
      end
    end
  endtask

  task automatic test_hazard;
    logic rv, bp;
    do_update(32'h0b, 32'd5);
    do_update(32'h0c, 32'd5);
    idle(2);
    do_lookup(32'h0b, 32'd6, rv, bp);
    exp_bp++;
    checks++;
    if (rv !== 1'b1 || bp !== 1'b1) begin
      failures++;
      $display("FAIL hz_base got valid=%b bypass=%b want valid=1 bypass=1", rv, bp);
    end
    do_update(32'h0b, 32'd6);
    do_lookup(32'h0b, 32'd1000, rv, bp);
    checks++;
    if (rv !== 1'b1 || bp !== 1'b0) begin
      failures++;
      $display("FAIL hz_next_cycle got valid=%b bypass=%b want valid=1 bypass=0", rv, bp);
    end
    bus.update_valid = 1'b1;
    bus.update_object = 32'h0c;
    bus.update_ts = 32'd7;
    do_lookup(32'h0c, 32'd1000, rv, bp);
    bus.update_valid = 1'b0;
    checks++;
    if (rv !== 1'b1 || bp !== 1'b0) begin
      failures++;
      $display("FAIL hz_same_cycle got valid=%b bypass=%b want valid=1 bypass=0", rv, bp);
    end
    do_update(32'h0d, 32'd5);
    idle(1);
    do_lookup(32'h0d, 32'd6, rv, bp);
    exp_bp++;
    checks++;
    if (rv !== 1'b1 || bp !== 1'b1) begin
      failures++;
      $display("FAIL hz_visible_2 got valid=%b bypass=%b want valid=1 bypass=1", rv, bp);
    end
    do_lookup(32'h0c, 32'd7, rv, bp);
    checks++;
    if (rv !== 1'b1 || bp !== 1'b0) begin
      failures++;
      $display("FAIL hz_after_c7 got valid=%b bypass=%b want valid=1 bypass=0", rv, bp);
    end
    do_lookup(32'h0c, 32'd8, rv, bp);
    exp_bp++;
    checks++;
    if (rv !== 1'b1 || bp !== 1'b1) begin
      failures++;
      $display("FAIL hz_after_c8 got valid=%b bypass=%b want valid=1 bypass=1", rv, bp);
    end
  endtask

  task automatic test_flush;
    logic [31:0] objs [7];
    logic rv, bp;
    int n = 0;
    objs = '{32'h20, 32'h205, 32'd7, 32'd8, 32'h203, 32'h0c, 32'h21};
    do_update(32'h20, 32'd5);
    idle(2);
    bus.lookup_valid = 1'b1;
    bus.lookup_object = 32'h20;
    bus.lookup_ts = 32'd6;
    bus.update_valid = 1'b1;
    bus.update_object = 32'h21;
    bus.update_ts = 32'd9;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    bus.update_valid = 1'b0;
    flush = 1'b1;
    exp_lk++;
    #1;
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_bypass !== 1'b0 || bus.lookup_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_pending got valid=%b bypass=%b ready=%b want valid=1 bypass=0 ready=0",
               bus.result_valid, bus.result_bypass, bus.lookup_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    while (bus.lookup_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 512) begin
      failures++;
      $display("FAIL flush_init_cycles got=%0d want=512", n);
    end
    for (int i = 0; i < 7; i++) begin
      do_lookup(objs[i], 32'd1000, rv, bp);
      checks++;
      if (rv !== 1'b1 || bp !== 1'b0) begin
        failures++;
        $display("FAIL flush_miss_%0d obj=%h got valid=%b bypass=%b want valid=1 bypass=0", i, objs[i], rv, bp);
      end
    end
    do_update(32'h20, 32'd5);
    idle(2);
    do_lookup(32'h20, 32'd6, rv, bp);
    exp_bp++;
    checks++;
    if (rv !== 1'b1 || bp !== 1'b1) begin
      failures++;
      $display("FAIL flush_reuse got valid=%b bypass=%b want valid=1 bypass=1", rv, bp);
    end
    idle(1);
`ifdef LAST_DEQ_VT_STATS_EN
    checks++;
    if (stat_lookups !== 32'(exp_lk) || stat_bypass !== 32'(exp_bp)) begin
      failures++;
      $display("FAIL stats got lookups=%0d bypass=%0d want lookups=%0d bypass=%0d", stat_lookups, stat_bypass, exp_lk, exp_bp);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_update_hit();
    test_monotonic();
    test_tag_replace();
    test_hazard();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
